float_op_arbiter: RTL and testbench
===================================

# float_op_arbiter

Round-robin scheduler that shares one pipelined 24-bit float operator (1 sign, 7-bit exponent bias 63, 16-bit mantissa) between NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the operator. It tracks each in-flight operation with a tag pipeline matching the operator latency, and routes each result plus underflow/overflow flags back to its originating requester. Per-requester sticky exception flags are also kept. It sits between requester logic and the shared float unit inside top_level.

## Interface
- NREQ, 4, number of requesters (2..8)
- LAT, 4, operator latency in cycles from op_valid to the matching op_result (≥1)
- W, 24, float word width

- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- req_valid  in  NREQ  requester i has an operand pair
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- op_valid  out  1  operands valid to operator this cycle
- op_a, op_b  out  W  operands to operator
- op_result  in  W  operator result, valid LAT cycles after op_valid
- op_underflow, op_overflow  in  1  operator exception flags, aligned with op_result
- rsp_valid  out  NREQ  one-hot; result for requester i this cycle
- rsp_data  out  W  result
- rsp_underflow, rsp_overflow  out  1  flags for rsp_data
- sticky_unf, sticky_ovf  out  NREQ  per-requester sticky exception flags
- sticky_clr  in  NREQ  clear sticky flags of requester i

## Operation
- Arbitration is combinational from req_valid and a pointer ptr (log2 NREQ bits, reset 0).
  - Search i = ptr, ptr+1, … mod NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1.
  - All other req_ready bits are 0. No grant when no valid.
- On a transfer from requester g:
  - register op_a←req_a[g], op_b←req_b[g], op_valid←1, ptr←(g+1) mod NREQ.
- With no transfer, op_valid←0. op_a/op_b hold their last values. ptr holds.
- Tag pipeline: LAT+1 stages of {valid, id}.
  - Stage 0 is loaded with {op_valid, id of the issued op}.
  - The last stage aligns with op_result.
  - op_result is ignored when the aligned tag is invalid.
- Response is registered.
  - rsp_valid[id]←1 for one cycle.
  - rsp_data, rsp_underflow and rsp_overflow are captured from the operator.
  - With no valid tag, rsp_valid←0 and the data outputs hold their last values.
- Requesters must accept responses; there is no response backpressure.
- Sticky flags:
  - sticky_unf[i] is set on a response to i with rsp_underflow=1; sticky_ovf[i] likewise with rsp_overflow=1.
  - sticky_clr[i] clears both flags of requester i.
  - A set and a clear in the same cycle: set wins.
- Reset values: ptr=0, op_valid=0, op_a=op_b=0, all tag valids=0, rsp_valid=0, rsp_data=0, rsp flags=0, sticky flags=0. req_ready follows combinationally from req_valid and ptr=0.

## Timing
- Transfer in cycle T → op_valid in T+1 → op_result in T+1+LAT → rsp_valid in T+2+LAT. Fixed latency LAT+2.
- Throughput: one operation per cycle. Back-to-back grants are allowed. Responses return in issue order.
- A single requester holding req_valid high is granted every cycle, since the rotation finds it again.
- All requesters valid: grants are strictly round-robin 0,1,2,3,0,….
- Pointer wrap: after granting NREQ-1, ptr=0.
- Reset asserted mid-operation:
  - all in-flight tags are discarded;
  - results arriving after reset release produce no rsp_valid;
  - requesters must reissue.
- req_a/req_b are sampled only in the transfer cycle. They may change freely otherwise.

## Test plan
- Reset/idle: assert rst at t=0, release at 202 ns, no requests.
  - Required: all outputs at reset values; req_ready=0; no op_valid; no rsp_valid.
- Single op, LAT=4: requester 2 presents a=0x469040 (200.125), b=0x3D8000 (0.375) at cycle T.
  - Required: op_valid at T+1 with those operands.
  - Required: rsp_valid=4'b0100 at T+6 with rsp_data equal to the operator output for that pair.
- Fairness: all four requesters held valid for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; one op_valid per cycle.
  - Required: responses return one per cycle, in the same order, each to the correct requester.
- Exceptions: requester 1 issues an op that overflows (a=0x7F0000, b=0x400000 with the multiplier).
  - Required: rsp_overflow=1 and sticky_ovf[1]=1, which stays set until sticky_clr[1].
  - Same-cycle set+clr: the flag remains 1.
- Reset mid-flight: issue 3 ops, then pulse rst for 1 cycle two cycles after the first op_valid.
  - Required: no rsp_valid for any of the 3 ops.
  - Required: ptr=0; the next request from requester 3 is granted normally.
- Sparse: requesters 0 and 3 alternate single-cycle valids with idle gaps.
  - Required: each is granted in its valid cycle; op_valid=0 in gap cycles; tags do not misroute results.

Source files
------------

// File: rtl/float_op_arbiter_if.sv
// Requester, operator and response signals of the shared float operator arbiter.
// The arbiter takes the slave modport; requester/operator logic takes the master modport.
interface float_op_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 24
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;

   logic              op_valid;
   logic [W-1:0]      op_a;
   logic [W-1:0]      op_b;
   logic [W-1:0]      op_result;
   logic              op_underflow;
   logic              op_overflow;

   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              rsp_underflow;
   logic              rsp_overflow;

   logic [NREQ-1:0]   sticky_unf;
   logic [NREQ-1:0]   sticky_ovf;
   logic [NREQ-1:0]   sticky_clr;

   modport slave (
      input  req_valid, req_a, req_b, sticky_clr,
      input  op_result, op_underflow, op_overflow,
      output req_ready, op_valid, op_a, op_b,
      output rsp_valid, rsp_data, rsp_underflow, rsp_overflow,
      output sticky_unf, sticky_ovf
   );

   modport master (
      output req_valid, req_a, req_b, sticky_clr,
      output op_result, op_underflow, op_overflow,
      input  req_ready, op_valid, op_a, op_b,
      input  rsp_valid, rsp_data, rsp_underflow, rsp_overflow,
      input  sticky_unf, sticky_ovf
   );
endinterface

// File: rtl/float_op_arbiter.sv
// Round-robin sharing of one pipelined float operator between NREQ requesters,
// with a tag pipeline that routes each result and its exception flags back to its issuer.
module float_op_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 4,
   parameter int W    = 24
) (
   input  logic             clk,
   input  logic             rst,
   float_op_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] grant_id;
   logic          grant_any;
   logic [PW:0]   search_sum;
   logic [PW-1:0] search_idx;

   always_comb begin
      grant_any     = 1'b0;
      grant_id      = '0;
      search_sum    = '0;
      search_idx    = '0;
      bus.req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         search_sum = {1'b0, ptr} + (PW+1)'(k);
         if (search_sum >= (PW+1)'(NREQ))
            search_sum = search_sum - (PW+1)'(NREQ);
         search_idx = search_sum[PW-1:0];
         if (!grant_any && bus.req_valid[search_idx]) begin
            grant_any = 1'b1;
            grant_id  = search_idx;
         end
      end
      if (grant_any)
         bus.req_ready[grant_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= '0;
         bus.op_valid <= 1'b0;
         bus.op_a     <= '0;
         bus.op_b     <= '0;
      end else if (grant_any) begin
         bus.op_valid <= 1'b1;
         bus.op_a     <= bus.req_a[grant_id*W +: W];
         bus.op_b     <= bus.req_b[grant_id*W +: W];
         ptr          <= (grant_id == PW'(NREQ-1)) ? '0 : grant_id + PW'(1);
      end else begin
         bus.op_valid <= 1'b0;
      end
   end

   // Stage 0 loads alongside op_valid, so stage LAT lines up with op_result.
   logic          tag_v  [LAT+1];
   logic [PW-1:0] tag_id [LAT+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s <= LAT; s++) begin
            tag_v[s]  <= 1'b0;
            tag_id[s] <= '0;
         end
      end else begin
         tag_v[0]  <= grant_any;
         tag_id[0] <= grant_id;
         for (int s = 1; s <= LAT; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   logic [NREQ-1:0] rsp_onehot;

   always_comb begin
      rsp_onehot = '0;
      if (tag_v[LAT])
         rsp_onehot[tag_id[LAT]] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rsp_valid     <= '0;
         bus.rsp_data      <= '0;
         bus.rsp_underflow <= 1'b0;
         bus.rsp_overflow  <= 1'b0;
      end else begin
         bus.rsp_valid <= rsp_onehot;
         if (tag_v[LAT]) begin
            bus.rsp_data      <= bus.op_result;
            bus.rsp_underflow <= bus.op_underflow;
            bus.rsp_overflow  <= bus.op_overflow;
         end
      end
   end

   // Sticky flags update on the same edge that registers the response; a set beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.sticky_unf <= '0;
         bus.sticky_ovf <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (rsp_onehot[i] && bus.op_underflow)
               bus.sticky_unf[i] <= 1'b1;
            else if (bus.sticky_clr[i])
               bus.sticky_unf[i] <= 1'b0;
            if (rsp_onehot[i] && bus.op_overflow)
               bus.sticky_ovf[i] <= 1'b1;
            else if (bus.sticky_clr[i])
               bus.sticky_ovf[i] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_float_op_arbiter.sv
// Bench for float_op_arbiter: behavioural float multiplier as the shared operator,
// round-robin grant model, and issue/response scoreboards checked every cycle.
module tb_float_op_arbiter;
   localparam int NREQ = 4;
   localparam int LAT  = 4;
   localparam int W    = 24;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   float_op_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   float_op_arbiter #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // {underflow, overflow, result}; 1 sign, 7-bit exponent bias 63, 16-bit mantissa, truncating
   function automatic logic [W+1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic        s;
      int          ea, eb, e;
      logic [33:0] p;
      logic [15:0] m;
      s  = a[23] ^ b[23];
      ea = int'(a[22:16]);
      eb = int'(b[22:16]);
      if (ea == 0 || eb == 0) return {2'b00, s, 23'd0};
      p = {17'd0, 1'b1, a[15:0]} * {17'd0, 1'b1, b[15:0]};
      e = ea + eb - 63;
      if (p[33]) begin
         e = e + 1;
         m = p[32:17];
      end else begin
         m = p[31:16];
      end
      if (e >= 127) return {2'b01, s, 7'h7F, 16'h0};
      if (e <= 0)   return {2'b10, s, 23'd0};
      return {2'b00, s, e[6:0], m};
   endfunction

   // Operator model: LAT-deep pipeline, runs every cycle regardless of op_valid.
   logic [W+1:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= fmul(bus.op_a, bus.op_b);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign bus.op_result    = pipe[LAT-1][W-1:0];
   assign bus.op_overflow  = pipe[LAT-1][W];
   assign bus.op_underflow = pipe[LAT-1][W+1];

   typedef struct { int due; logic [W-1:0] a; logic [W-1:0] b; } op_t;
   typedef struct { int due; int id; logic [W+1:0] r; } rsp_t;
   op_t  op_q [$];
   rsp_t rsp_q[$];
   int   mptr = 0;

   logic [W-1:0] opa [NREQ];
   logic [W-1:0] opb [NREQ];

   always @(negedge clk) begin
      if (!rst) begin
         if (op_q.size() > 0 && op_q[0].due == cyc) begin
            chk("op_valid", 32'(bus.op_valid), 32'd1);
            chk("op_a", 32'(bus.op_a), 32'(op_q[0].a));
            chk("op_b", 32'(bus.op_b), 32'(op_q[0].b));
            void'(op_q.pop_front());
         end else begin
            chk("op_idle", 32'(bus.op_valid), 32'd0);
         end
         if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << rsp_q[0].id);
            chk("rsp_data", 32'(bus.rsp_data), 32'(rsp_q[0].r[W-1:0]));
            chk("rsp_ovf", 32'(bus.rsp_overflow), 32'(rsp_q[0].r[W]));
            chk("rsp_unf", 32'(bus.rsp_underflow), 32'(rsp_q[0].r[W+1]));
            void'(rsp_q.pop_front());
         end else begin
            chk("rsp_idle", 32'(bus.rsp_valid), 32'd0);
         end
      end
   end

   // One cycle: drive at posedge+1, check grant at negedge, leave at next posedge+1.
   task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] clr, output int g);
      logic [NREQ-1:0] exp_rdy;
      op_t  o;
      rsp_t r;
      bus.req_valid  = v;
      bus.sticky_clr = clr;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*W +: W] = opa[i];
         bus.req_b[i*W +: W] = opb[i];
      end
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         if (g < 0 && v[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (g >= 0) begin
         o.due = cyc + 1; o.a = opa[g]; o.b = opb[g];
         op_q.push_back(o);
         r.due = cyc + LAT + 2; r.id = g; r.r = fmul(opa[g], opb[g]);
         rsp_q.push_back(r);
         mptr = (g + 1) % NREQ;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      int g;
      for (int k = 0; k < n; k++) drive_cycle('0, '0, g);
   endtask

   initial begin
      int g;
      rst = 1'b1;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.sticky_clr = '0;
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = '0;
         opb[i] = '0;
      end

      #100;
      chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
      chk("rst_op_a", 32'(bus.op_a), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_sticky", 32'({bus.sticky_unf, bus.sticky_ovf}), 32'd0);
      #102;
      rst = 1'b0;
      @(posedge clk);
      #1;
      idle(3);

      // Fairness: everyone valid for 8 cycles
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            opa[i] = 24'({1'b0, 7'd63, 16'($urandom())});
            opb[i] = 24'({1'b0, 7'd62, 16'($urandom())});
         end
         drive_cycle('1, '0, g);
         chk("rr_order", 32'(g), 32'(k % NREQ));
      end
      idle(LAT + 3);

      // Single op from requester 2
      opa[2] = 24'h469040;
      opb[2] = 24'h3D8000;
      drive_cycle(4'b0100, '0, g);
      idle(LAT + 1);
      chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      chk("single_rsp_data", 32'(bus.rsp_data), 32'h452C30);
      idle(2);

      // Overflow, sticky hold, clear
      opa[1] = 24'h7F0000;
      opb[1] = 24'h400000;
      drive_cycle(4'b0010, '0, g);
      idle(LAT + 2);
      chk("sticky_ovf_set", 32'(bus.sticky_ovf), 32'h2);
      idle(3);
      chk("sticky_ovf_hold", 32'(bus.sticky_ovf), 32'h2);
      drive_cycle('0, 4'b0010, g);
      chk("sticky_ovf_clr", 32'(bus.sticky_ovf), 32'h0);

      // Set and clear in the same cycle: set wins
      drive_cycle(4'b0010, '0, g);
      idle(LAT);
      drive_cycle('0, 4'b0010, g);
      chk("sticky_set_clr", 32'(bus.sticky_ovf), 32'h2);
      drive_cycle('0, 4'b0010, g);
      chk("sticky_clr2", 32'(bus.sticky_ovf), 32'h0);

      // Underflow from requester 0
      opa[0] = 24'h010000;
      opb[0] = 24'h010000;
      drive_cycle(4'b0001, '0, g);
      idle(LAT + 2);
      chk("sticky_unf_set", 32'(bus.sticky_unf), 32'h1);
      chk("sticky_ovf_quiet", 32'(bus.sticky_ovf), 32'h0);

      // Reset mid-flight: three ops, reset two cycles after the first op_valid
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = 24'h4A1234 + 24'(i);
         opb[i] = 24'h3F8000;
      end
      drive_cycle(4'b0001, '0, g);
      drive_cycle(4'b0010, '0, g);
      drive_cycle(4'b0100, '0, g);
      rst = 1'b1;
      bus.req_valid = '0;
      op_q.delete();
      rsp_q.delete();
      mptr = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(LAT + 4);
      drive_cycle(4'b1010, '0, g);
      chk("post_rst_ptr", 32'(g), 32'd1);
      drive_cycle(4'b1000, '0, g);
      chk("post_rst_req3", 32'(g), 32'd3);
      idle(LAT + 3);

      // Sparse: requesters 0 and 3 alternate with idle gaps
      for (int k = 0; k < 12; k++) begin
         opa[0] = 24'($urandom()); opb[0] = 24'($urandom());
         opa[3] = 24'($urandom()); opb[3] = 24'($urandom());
         case (k % 4)
            0:       drive_cycle(4'b0001, '0, g);
            2:       drive_cycle(4'b1000, '0, g);
            default: drive_cycle(4'b0000, '0, g);
         endcase
         chk("sparse_grant", 32'(g), (k % 4 == 0) ? 32'd0 : (k % 4 == 2) ? 32'd3 : 32'hFFFFFFFF);
      end
      idle(LAT + 4);
      chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
      chk("drain_op_q", 32'(op_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
